memory_arbiter: RTL

- Single-ported main-memory model that sits directly downstream of the instruction cache and the data cache.
- Accepts line-fill (miss) requests from both caches and arbitrates between them round-robin.
- Serves one request at a time with a fixed MEM_LATENCY, returning full cache lines.
- Also accepts line write-backs (stores) from the data cache and acknowledges them.

---
 rtl/memory_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-ported main-memory model shared by the icache and
// dcache. Round-robin arbitration, fixed MEM_LATENCY from grant to response,
// full-line fills and dcache line write-backs.
module memory_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned LINE_WIDTH  = 128,
   parameter int unsigned MEM_LINES   = 1024,
   parameter int unsigned MEM_LATENCY = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ic_req_valid,
   input  logic [ADDR_WIDTH-1:0] ic_req_addr,
   output logic                  ic_rsp_valid,
   output logic [LINE_WIDTH-1:0] ic_rsp_data,
   input  logic                  dc_req_valid,
   input  logic [ADDR_WIDTH-1:0] dc_req_addr,
   input  logic                  dc_req_is_store,
   input  logic [LINE_WIDTH-1:0] dc_req_data,
   output logic                  dc_rsp_valid,
   output logic [LINE_WIDTH-1:0] dc_rsp_data
);

   localparam int unsigned OFF   = $clog2(LINE_WIDTH / 8);
   localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
   localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   typedef enum logic {PORT_IC, PORT_DC} port_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   port_t             gnt, gnt_nxt, last_grant, resp_port;
   logic [IDX_W-1:0]  gnt_idx, grant_idx, rd_idx;
   logic              do_grant, enter_resp;

   logic              ic_pend, dc_pend;
   logic [IDX_W-1:0]  ic_idx_q, dc_idx_q, ic_idx, dc_idx;
   logic              dc_store_q, dc_store_eff;
   logic [LINE_WIDTH-1:0] dc_data_q;
   logic              ic_cap, dc_cap, ic_want, dc_want;

   logic [LINE_WIDTH-1:0] mem [MEM_LINES];

   // Upper and offset address bits deliberately do not take part in indexing.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ic_req_addr, dc_req_addr};

   // A request is captured when idle on its port, but never during its own
   // response cycle so a combinationally echoed valid is not re-captured.
   // Grant decisions also see a request arriving this cycle, so a grant
   // does not have to wait for the pending flag to be registered.
   always_comb begin
      ic_cap       = ic_req_valid & ~ic_pend & ~ic_rsp_valid;
      dc_cap       = dc_req_valid & ~dc_pend & ~dc_rsp_valid;
      ic_want      = ic_pend | ic_cap;
      dc_want      = dc_pend | dc_cap;
      ic_idx       = ic_pend ? ic_idx_q : ic_req_addr[OFF +: IDX_W];
      dc_idx       = dc_pend ? dc_idx_q : dc_req_addr[OFF +: IDX_W];
      dc_store_eff = dc_pend ? dc_store_q : dc_req_is_store;
   end

   // Next-state, arbitration and response-launch decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      gnt_nxt   = gnt;
      do_grant  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ic_want || dc_want) begin
               do_grant = 1'b1;
               if (ic_want && dc_want)
                  gnt_nxt = (last_grant == PORT_DC) ? PORT_IC : PORT_DC;
               else
                  gnt_nxt = ic_want ? PORT_IC : PORT_DC;
               if (MEM_LATENCY == 1) begin
                  state_nxt = ST_RESP;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
               state_nxt = ST_RESP;
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      grant_idx  = (gnt_nxt == PORT_IC) ? ic_idx : dc_idx;
      enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
      rd_idx     = (state == ST_IDLE) ? grant_idx : gnt_idx;
      resp_port  = (state == ST_IDLE) ? gnt_nxt : gnt;
   end

   // FSM state, latency counter and grant bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         gnt        <= PORT_IC;
         last_grant <= PORT_DC;
         gnt_idx    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         gnt   <= gnt_nxt;
         if (do_grant) begin
            last_grant <= gnt_nxt;
            gnt_idx    <= grant_idx;
         end
      end
   end

   // Per-port pending flags and latched request fields.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ic_pend    <= 1'b0;
         dc_pend    <= 1'b0;
         ic_idx_q   <= '0;
         dc_idx_q   <= '0;
         dc_store_q <= 1'b0;
         dc_data_q  <= '0;
      end else begin
         if (ic_rsp_valid) begin
            ic_pend <= 1'b0;
         end else if (ic_cap) begin
            ic_pend  <= 1'b1;
            ic_idx_q <= ic_req_addr[OFF +: IDX_W];
         end
         if (dc_rsp_valid) begin
            dc_pend <= 1'b0;
         end else if (dc_cap) begin
            dc_pend    <= 1'b1;
            dc_idx_q   <= dc_req_addr[OFF +: IDX_W];
            dc_store_q <= dc_req_is_store;
            dc_data_q  <= dc_req_data;
         end
      end
   end

   // Registered responses: one-cycle pulse with data, zero otherwise.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ic_rsp_valid <= 1'b0;
         ic_rsp_data  <= '0;
         dc_rsp_valid <= 1'b0;
         dc_rsp_data  <= '0;
      end else begin
         ic_rsp_valid <= 1'b0;
         ic_rsp_data  <= '0;
         dc_rsp_valid <= 1'b0;
         dc_rsp_data  <= '0;
         if (enter_resp) begin
            if (resp_port == PORT_IC) begin
               ic_rsp_valid <= 1'b1;
               ic_rsp_data  <= mem[rd_idx];
            end else begin
               dc_rsp_valid <= 1'b1;
               dc_rsp_data  <= dc_store_eff ? '0 : mem[rd_idx];
            end
         end
      end
   end

   // Write-back commits at the end of the response cycle; the store is not reset.
   always_ff @(posedge clock) begin
      if (state == ST_RESP && gnt == PORT_DC && dc_store_q)
         mem[gnt_idx] <= dc_data_q;
   end

endmodule
